testeio_start_chrom: RTL and testbench

Avalon-MM write-side control port that hands a chromosome word to the genetic-circuit datapath and launches its processing. The CPU writes the word and a start command; the block raises `start` until the datapath sends `ack`, then waits for a rising edge on `done` and records completion in a sticky status bit. It is the command/output counterpart of the read-only done-status input port and sits on the same system interconnect as the other PIO slaves.

---
 rtl/testeio_pio_pkg.sv | 21 ++
 rtl/testeio_run_timer.sv | 25 ++
 rtl/testeio_start_chrom.sv | 149 ++++++++++++++
 tb/tb_testeio_start_chrom.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/testeio_pio_pkg.sv
// Shared definitions for the testeio PIO slaves: register map, status bit
// positions and the start-port state encoding.
package testeio_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_CLEAR   = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

    localparam int CTRL_START_BIT   = 0;
    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_TIMEOUT_BIT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RUN  = 2'd2
    } start_state_t;

endpackage

// File: rtl/testeio_run_timer.sv
// Clearable cycle counter with compare-to-limit; a zero limit never expires.
module testeio_run_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [31:0] i_limit,
    output logic        o_expired
);

    logic [31:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_expired = i_enable && (i_limit != 32'd0) && (r_count == i_limit);

endmodule

// File: rtl/testeio_start_chrom.sv
// Avalon-MM start/command port for the chromosome datapath: DATA word, start
// handshake (start/ack), done-edge completion. TESTEIO_START_CHROM_TIMEOUT_EN adds a RUN timeout.
module testeio_start_chrom
    import testeio_pio_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter logic [31:0] RESET_VALUE   = 32'h0,
    parameter logic [31:0] TIMEOUT_RESET = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  start,
    input  logic                  ack,
    input  logic                  done
);

    start_state_t          r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_done_d;
    logic                  r_done_flag, w_done_flag_next;
    logic                  r_timeout, w_timeout_next;
    logic [31:0]           r_readdata, w_readdata_next;
    logic [31:0]           w_data_ext;
    logic [31:0]           w_limit;
    logic                  w_timer_hit;

    logic w_wr, w_busy, w_start_cmd, w_clear, w_done_edge;

    assign w_wr        = chipselect && !write_n;
    assign w_busy      = (r_state != IDLE);
    assign w_start_cmd = w_wr && (address == ADDR_CTRL) && writedata[CTRL_START_BIT];
    assign w_clear     = w_wr && (address == ADDR_CLEAR);
    assign w_done_edge = done && !r_done_d;

`ifdef TESTEIO_START_CHROM_TIMEOUT_EN
    logic [31:0] r_limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_limit <= TIMEOUT_RESET;
        end else if (w_wr && (address == ADDR_TIMEOUT)) begin
            r_limit <= writedata;
        end
    end

    // Clearing on the REQ->RUN transition makes the count start at 0 in RUN.
    testeio_run_timer u_run_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   ((r_state == REQ) && ack),
        .i_enable  (r_state == RUN),
        .i_limit   (r_limit),
        .o_expired (w_timer_hit)
    );

    assign w_limit = r_limit;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_RESET;
    assign w_timer_hit  = 1'b0;
    assign w_limit      = 32'd0;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_done_flag_next = r_done_flag;
        w_timeout_next   = r_timeout;
        if (w_clear) begin
            w_done_flag_next = 1'b0;
            w_timeout_next   = 1'b0;
        end
        case (r_state)
            IDLE: begin
                if (w_start_cmd) begin
                    w_state_next     = REQ;
                    w_done_flag_next = 1'b0;
                    w_timeout_next   = 1'b0;
                end
            end
            REQ: begin
                if (ack) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // A done edge beats both a same-cycle CLEAR and a timer expiry.
                if (w_done_edge) begin
                    w_state_next     = IDLE;
                    w_done_flag_next = 1'b1;
                end else if (w_timer_hit) begin
                    w_state_next   = IDLE;
                    w_timeout_next = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_data_ext                 = '0;
        w_data_ext[DATA_WIDTH-1:0] = r_data;
    end

    always_comb begin
        w_readdata_next = '0;
        case (address)
            ADDR_DATA:    w_readdata_next = w_data_ext;
            ADDR_CTRL: begin
                w_readdata_next[STAT_BUSY_BIT]    = w_busy;
                w_readdata_next[STAT_DONE_BIT]    = r_done_flag;
                w_readdata_next[STAT_TIMEOUT_BIT] = r_timeout;
            end
            ADDR_TIMEOUT: w_readdata_next = w_limit;
            default:      w_readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_data      <= RESET_VALUE[DATA_WIDTH-1:0];
            r_done_d    <= 1'b0;
            r_done_flag <= 1'b0;
            r_timeout   <= 1'b0;
            r_readdata  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_done_d    <= done;
            r_done_flag <= w_done_flag_next;
            r_timeout   <= w_timeout_next;
            r_readdata  <= w_readdata_next;
            // out_port is frozen for the whole run.
            if (w_wr && (address == ADDR_DATA) && !w_busy) begin
                r_data <= writedata[DATA_WIDTH-1:0];
            end
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_data;
    assign start    = (r_state == REQ);

endmodule

// File: tb/tb_testeio_start_chrom.sv
// Directed self-checking bench for testeio_start_chrom (timeout cases run
// only when TESTEIO_START_CHROM_TIMEOUT_EN is defined).
module tb_testeio_start_chrom;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        start;
    logic        ack = 1'b0;
    logic        done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] RV = 32'h0000_005A;

    testeio_start_chrom #(
        .DATA_WIDTH    (32),
        .RESET_VALUE   (RV),
        .TIMEOUT_RESET (32'd0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .start      (start),
        .ack        (ack),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        $display("[TB] write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(posedge clk); #1;
        d = readdata;
        $display("[TB] read  addr=%0d data=0x%08h", a, d);
    endtask

    // Issue a start and acknowledge it on the first REQ cycle, leaving the DUT in RUN.
    task automatic go_run();
        bus_write(2'd1, 32'd1);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (start !== 1'b0 || readdata !== 32'd0 || out_port !== RV) begin
            n_fail++;
            $display("FAIL reset_outputs: start=%b readdata=0x%08h out_port=0x%08h, expected 0/0/0x%08h",
                     start, readdata, out_port, RV);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), rd);
            n_tests++;
            if (rd !== ((i == 0) ? RV : 32'd0)) begin
                n_fail++;
                $display("FAIL reset_read_addr%0d: got 0x%08h expected 0x%08h",
                         i, rd, (i == 0) ? RV : 32'd0);
            end
        end
    endtask

    task automatic test_run();
        logic [31:0] rd;
        int hi_cycles;
        bus_write(2'd0, 32'hA5A5_1234);
        n_tests++;
        if (out_port !== 32'hA5A5_1234) begin
            n_fail++;
            $display("FAIL data_write: out_port=0x%08h expected 0xa5a51234", out_port);
        end
        bus_read(2'd0, rd);
        n_tests++;
        if (rd !== 32'hA5A5_1234) begin
            n_fail++;
            $display("FAIL data_read: got 0x%08h expected 0xa5a51234", rd);
        end
        bus_write(2'd1, 32'd1);
        hi_cycles = (start === 1'b1) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (start === 1'b1) hi_cycles++;
        end
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        n_tests++;
        if (hi_cycles != 3 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL start_pulse: high cycles=%0d start_after_ack=%b, expected 3/0", hi_cycles, start);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (start !== 1'b0 || out_port !== 32'hA5A5_1234) begin
                n_fail++;
                $display("FAIL run_hold: start=%b out_port=0x%08h expected 0/0xa5a51234", start, out_port);
            end
        end
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd1) begin
            n_fail++;
            $display("FAIL run_busy: ctrl=0x%08h expected 0x00000001", rd);
        end
        pulse_done();
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd2) begin
            n_fail++;
            $display("FAIL run_done: ctrl=0x%08h expected 0x00000002", rd);
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] rd;
        go_run();
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd1) begin
            n_fail++;
            $display("FAIL start_clears_done: ctrl=0x%08h expected 0x00000001", rd);
        end
        bus_write(2'd0, 32'hFFFF_FFFF);
        n_tests++;
        if (out_port !== 32'hA5A5_1234) begin
            n_fail++;
            $display("FAIL busy_data_drop: out_port=0x%08h expected 0xa5a51234", out_port);
        end
        bus_write(2'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (start !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_start_ignored: start=%b expected 0 (cycle %0d)", start, i);
            end
            @(posedge clk); #1;
        end
        pulse_done();
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd2 || out_port !== 32'hA5A5_1234) begin
            n_fail++;
            $display("FAIL busy_finish: ctrl=0x%08h out_port=0x%08h expected 0x00000002/0xa5a51234", rd, out_port);
        end
    endtask

    task automatic test_done_in_req();
        logic [31:0] rd;
        bus_write(2'd1, 32'd1);
        done = 1'b1;
        @(posedge clk); #1;
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        repeat (3) @(posedge clk);
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd1) begin
            n_fail++;
            $display("FAIL done_in_req_ignored: ctrl=0x%08h expected 0x00000001", rd);
        end
        done = 1'b0;
        @(posedge clk); #1;
        pulse_done();
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd2) begin
            n_fail++;
            $display("FAIL done_after_req: ctrl=0x%08h expected 0x00000002", rd);
        end
    endtask

    task automatic test_clear_collision();
        logic [31:0] rd;
        go_run();
        @(negedge clk);
        done = 1'b1; address = 2'd2; writedata = 32'd0; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; done = 1'b0;
        $display("[TB] clear write coincident with done edge");
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd2) begin
            n_fail++;
            $display("FAIL clear_vs_done: ctrl=0x%08h expected 0x00000002", rd);
        end
        bus_write(2'd2, 32'd0);
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL clear_later: ctrl=0x%08h expected 0x00000000", rd);
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] rd;
        go_run();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (start !== 1'b0 || readdata !== 32'd0 || out_port !== RV) begin
            n_fail++;
            $display("FAIL midrun_reset: start=%b readdata=0x%08h out_port=0x%08h expected 0/0/0x%08h",
                     start, readdata, out_port, RV);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_status: ctrl=0x%08h expected 0x00000000", rd);
        end
        bus_write(2'd1, 32'd1);
        n_tests++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_start: start=%b expected 1", start);
        end
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        pulse_done();
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd2 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_done: ctrl=0x%08h start=%b expected 0x00000002/0", rd, start);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
`ifdef TESTEIO_START_CHROM_TIMEOUT_EN
        bus_write(2'd3, 32'd5);
        bus_read(2'd3, rd);
        n_tests++;
        if (rd !== 32'd5) begin
            n_fail++;
            $display("FAIL timeout_reg: got 0x%08h expected 0x00000005", rd);
        end
        go_run();
        rd = 32'd1;
        for (int i = 0; i < 30 && rd[0] === 1'b1; i++) begin
            bus_read(2'd1, rd);
        end
        n_tests++;
        if (rd !== 32'd4) begin
            n_fail++;
            $display("FAIL timeout_hit: ctrl=0x%08h expected 0x00000004 within 30 reads", rd);
        end
        bus_write(2'd3, 32'd0);
        go_run();
        repeat (1000) @(posedge clk);
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd1) begin
            n_fail++;
            $display("FAIL timeout_zero: ctrl=0x%08h expected 0x00000001", rd);
        end
        pulse_done();
        bus_read(2'd1, rd);
        n_tests++;
        if (rd !== 32'd2) begin
            n_fail++;
            $display("FAIL timeout_zero_done: ctrl=0x%08h expected 0x00000002", rd);
        end
`else
        bus_write(2'd3, 32'd5);
        bus_read(2'd3, rd);
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout_absent: got 0x%08h expected 0x00000000", rd);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_run();
        test_busy_writes();
        test_done_in_req();
        test_clear_collision();
        test_reset_midrun();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
